// File: rtl/debounce_multi.sv
// ----------------------------------------------------------------------------
// debounce_multi
//
// Multi-channel push-button debouncer. Each channel synchronises its raw input
// through two flops, then requires STABLE_CYCLES consecutive samples that
// disagree with the current debounced level before the level flips. Press and
// release edges produce one-cycle pulses. With REPEAT_EN=1, a held button also
// produces auto-repeat pulses: the first REPEAT_DELAY cycles after the press
// pulse, then one every REPEAT_RATE cycles until release.
//
// Ports:
//   clk       in   1     system clock, rising edge
//   reset     in   1     asynchronous, active-high; clears all state
//   Din       in   N_CH  raw asynchronous button inputs (bit i = channel i)
//   Dlevel    out  N_CH  debounced level
//   Dpress    out  N_CH  one-cycle pulse on debounced 0->1
//   Drelease  out  N_CH  one-cycle pulse on debounced 1->0
//   Drepeat   out  N_CH  one-cycle auto-repeat pulse (0 when REPEAT_EN=0)
//   Devent    out  N_CH  registered Dpress | Drepeat
// ----------------------------------------------------------------------------
module debounce_multi #(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 250,
    parameter int REPEAT_RATE   = 50
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] Din,
    output logic [N_CH-1:0] Dlevel,
    output logic [N_CH-1:0] Dpress,
    output logic [N_CH-1:0] Drelease,
    output logic [N_CH-1:0] Drepeat,
    output logic [N_CH-1:0] Devent
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    // Counters only ever need to reach their terminal value minus one.
    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int RW = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST   = RW'(REPEAT_RATE - 1);

    logic [N_CH-1:0]         s1_q, s1_d;
    logic [N_CH-1:0]         s2_q, s2_d;
    logic [N_CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]         level_q, level_d;
    logic [N_CH-1:0]         press_q, press_d;
    logic [N_CH-1:0]         rel_q, rel_d;
    logic [N_CH-1:0]         rep_q, rep_d;
    logic [N_CH-1:0]         evt_q, evt_d;
    logic [N_CH-1:0][RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [N_CH-1:0]         rpt_flag_q, rpt_flag_d;
    logic [N_CH-1:0]         flip;

    always_comb begin
        s1_d       = Din;
        s2_d       = s1_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        press_d    = '0;
        rel_d      = '0;
        rep_d      = '0;
        evt_d      = '0;
        rpt_cnt_d  = rpt_cnt_q;
        rpt_flag_d = rpt_flag_q;
        flip       = '0;

        for (int i = 0; i < N_CH; i++) begin
            // Any agreeing sample restarts qualification from zero.
            if (s2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == STABLE_LAST) begin
                cnt_d[i]   = '0;
                level_d[i] = ~level_q[i];
                flip[i]    = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end

            press_d[i] = flip[i] & ~level_q[i];
            rel_d[i]   = flip[i] & level_q[i];

            if (REPEAT_EN != 0) begin
                // Held low, or falling on this edge: clear so a release
                // cancels any repeat that would otherwise land on this edge.
                if (!level_q[i] || flip[i]) begin
                    rpt_cnt_d[i]  = '0;
                    rpt_flag_d[i] = 1'b0;
                end else if (!rpt_flag_q[i] && (rpt_cnt_q[i] == DELAY_LAST)) begin
                    rep_d[i]      = 1'b1;
                    rpt_flag_d[i] = 1'b1;
                    rpt_cnt_d[i]  = '0;
                end else if (rpt_flag_q[i] && (rpt_cnt_q[i] == RATE_LAST)) begin
                    rep_d[i]     = 1'b1;
                    rpt_cnt_d[i] = '0;
                end else begin
                    rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
                end
            end

            evt_d[i] = press_d[i] | rep_d[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            cnt_q      <= '0;
            level_q    <= '0;
            press_q    <= '0;
            rel_q      <= '0;
            rep_q      <= '0;
            evt_q      <= '0;
            rpt_cnt_q  <= '0;
            rpt_flag_q <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            rep_q      <= rep_d;
            evt_q      <= evt_d;
            rpt_cnt_q  <= rpt_cnt_d;
            rpt_flag_q <= rpt_flag_d;
        end
    end

    assign Dlevel   = level_q;
    assign Dpress   = press_q;
    assign Drelease = rel_q;
    assign Drepeat  = rep_q;
    assign Devent   = evt_q;

endmodule

// File: tb/tb_debounce_multi.sv
// ----------------------------------------------------------------------------
// tb_debounce_multi
//
// Bench for debounce_multi with N_CH=4, STABLE_CYCLES=8, REPEAT_EN=1,
// REPEAT_DELAY=20, REPEAT_RATE=5. Inputs change on the falling edge; a value
// driven after rising edge k is first sampled at edge k+1, so the debounced
// level changes at edge k+10. Every expected output event is a record
// {edge number, channel, level, press, release, repeat, event} pushed when
// the stimulus is issued; the monitor pops one record for each channel that
// shows a pulse or a level change at a falling edge.
// ----------------------------------------------------------------------------
module tb_debounce_multi;

    localparam int N_CH = 4;
    localparam int W    = 41;

    logic            clk   = 1'b0;
    logic            reset = 1'b0;
    logic [N_CH-1:0] Din   = '0;
    logic [N_CH-1:0] Dlevel, Dpress, Drelease, Drepeat, Devent;

    int edge_cnt = 0;
    int checks   = 0;
    int errors   = 0;

    logic [W-1:0] exp_q[$];

    debounce_multi #(
        .N_CH          (N_CH),
        .STABLE_CYCLES (8),
        .REPEAT_EN     (1),
        .REPEAT_DELAY  (20),
        .REPEAT_RATE   (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Din      (Din),
        .Dlevel   (Dlevel),
        .Dpress   (Dpress),
        .Drelease (Drelease),
        .Drepeat  (Drepeat),
        .Devent   (Devent)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] mk(input int cyc, input int ch, input logic lv,
                                        input logic pr, input logic rl, input logic rp);
        logic [31:0] c32;
        logic [3:0]  ch4;
        c32 = 32'(cyc);
        ch4 = 4'(ch);
        return {c32, ch4, lv, pr, rl, rp, pr | rp};
    endfunction

    task automatic push_ev(input int cyc, input int ch, input logic lv,
                           input logic pr, input logic rl, input logic rp);
        exp_q.push_back(mk(cyc, ch, lv, pr, rl, rp));
    endtask

    // Press at edge p, repeats at p+20, p+25, ... strictly before the release
    // edge r (a repeat due on r is cancelled), release at r.
    task automatic push_hold(input int ch, input int p, input int r);
        push_ev(p, ch, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int t = p + 20; t < r; t += 5)
            push_ev(t, ch, 1'b1, 1'b0, 1'b0, 1'b1);
        push_ev(r, ch, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic wait_until(input int c);
        while (edge_cnt < c) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // ---------------- driver ----------------
    initial begin
        int d;
        int q;

        // Reset asserted between clock edges: outputs must clear at once.
        #1 reset = 1'b1;
        #1;
        check("reset_level",   32'(Dlevel),   32'h0);
        check("reset_press",   32'(Dpress),   32'h0);
        check("reset_release", 32'(Drelease), 32'h0);
        check("reset_repeat",  32'(Drepeat),  32'h0);
        check("reset_event",   32'(Devent),   32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Ch0 press, hold, release; last repeat slot coincides with release.
        d = edge_cnt;
        Din[0] = 1'b1;
        push_hold(0, d + 10, d + 50);
        wait_until(d + 9);
        check("t1_level_before_e9", 32'(Dlevel), 32'h0);
        wait_until(d + 10);
        check("t1_level_e9", 32'(Dlevel), 32'h1);
        check("t1_press_e9", 32'(Dpress), 32'h1);
        wait_until(d + 11);
        check("t1_press_e10", 32'(Dpress), 32'h0);
        check("t1_level_e10", 32'(Dlevel), 32'h1);
        wait_until(d + 30);
        check("t1_first_repeat", 32'(Drepeat), 32'h1);
        wait_until(d + 40);
        Din[0] = 1'b0;
        wait_until(d + 50);
        check("t1_release_no_repeat", 32'(Drepeat), 32'h0);
        wait_until(d + 60);
        check("t1_level_after", 32'(Dlevel), 32'h0);

        // Ch1 glitch: only 7 high samples, never qualifies.
        d = edge_cnt;
        Din[1] = 1'b1;
        wait_until(d + 7);
        Din[1] = 1'b0;
        wait_until(d + 20);
        check("t2_glitch_level", 32'(Dlevel), 32'h0);

        // Ch1 high 20 cycles with one low sample at cycle 5.
        d = edge_cnt;
        Din[1] = 1'b1;
        push_hold(1, d + 16, d + 30);
        wait_until(d + 5);
        Din[1] = 1'b0;
        wait_until(d + 6);
        Din[1] = 1'b1;
        wait_until(d + 15);
        check("t2b_level_not_yet", 32'(Dlevel), 32'h0);
        wait_until(d + 16);
        check("t2b_level_rise", 32'(Dlevel), 32'h2);
        wait_until(d + 20);
        Din[1] = 1'b0;
        wait_until(d + 35);

        // Ch2 short press then release.
        d = edge_cnt;
        Din[2] = 1'b1;
        push_hold(2, d + 10, d + 22);
        wait_until(d + 12);
        Din[2] = 1'b0;
        wait_until(d + 21);
        check("t3_level_held", 32'(Dlevel), 32'h4);
        wait_until(d + 22);
        check("t3_release", 32'(Drelease), 32'h4);
        check("t3_level_low", 32'(Dlevel), 32'h0);
        wait_until(d + 35);

        // Ch3 auto-repeat, held 50 cycles past the press.
        d = edge_cnt;
        Din[3] = 1'b1;
        push_hold(3, d + 10, d + 70);
        wait_until(d + 30);
        check("t4_repeat_first", 32'(Drepeat), 32'h8);
        check("t4_event_first",  32'(Devent),  32'h8);
        wait_until(d + 31);
        check("t4_repeat_gap", 32'(Drepeat), 32'h0);
        wait_until(d + 60);
        Din[3] = 1'b0;
        wait_until(d + 80);

        // All channels together, staggered releases.
        d = edge_cnt;
        Din = 4'b1111;
        for (int i = 0; i < N_CH; i++) push_ev(d + 10, i, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < N_CH; i++) push_ev(d + 22 + i, i, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_until(d + 10);
        check("t5_press_all", 32'(Dpress), 32'hf);
        wait_until(d + 12); Din = 4'b1110;
        wait_until(d + 13); Din = 4'b1100;
        wait_until(d + 14); Din = 4'b1000;
        wait_until(d + 15); Din = 4'b0000;
        wait_until(d + 23);
        check("t5_release_ch1", 32'(Drelease), 32'h2);
        wait_until(d + 35);

        // Reset with ch0 mid-qualification (counter 5) and ch2 repeating.
        d = edge_cnt;
        Din[2] = 1'b1;
        push_ev(d + 10, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        push_ev(d + 30, 2, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_until(d + 25);
        Din[0] = 1'b1;
        wait_until(d + 32);
        check("t6_level_before_reset", 32'(Dlevel), 32'h4);
        #2 reset = 1'b1;
        #1;
        check("t6_async_level", 32'(Dlevel), 32'h0);
        check("t6_async_event", 32'(Devent), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        q = edge_cnt;
        push_ev(q + 10, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_ev(q + 10, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        push_ev(q + 22, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        push_ev(q + 22, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_until(q + 9);
        check("t6_level_not_yet", 32'(Dlevel), 32'h0);
        wait_until(q + 10);
        check("t6_press_fresh", 32'(Dpress), 32'h5);
        wait_until(q + 12);
        Din = '0;
        wait_until(q + 35);

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [N_CH-1:0] prev_level;
        logic [W-1:0]    obs;
        logic [W-1:0]    exp;
        prev_level = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_level = '0;
            end else begin
                for (int i = 0; i < N_CH; i++) begin
                    if (Dpress[i] || Drelease[i] || Drepeat[i] || Devent[i] ||
                        (Dlevel[i] != prev_level[i])) begin
                        obs = {32'(edge_cnt), 4'(i), Dlevel[i], Dpress[i], Drelease[i],
                               Drepeat[i], Devent[i]};
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_event: got edge %0d ch %0d bits %b, none expected",
                                     edge_cnt, i, obs[4:0]);
                        end else begin
                            exp = exp_q.pop_front();
                            if (obs !== exp) begin
                                errors++;
                                $display("FAIL event: got edge %0d ch %0d bits %b expected edge %0d ch %0d bits %b",
                                         obs[40:9], obs[8:5], obs[4:0], exp[40:9], exp[8:5], exp[4:0]);
                            end
                        end
                    end
                end
                prev_level = Dlevel;
            end
        end
    end

endmodule
